dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- Load/store front-end placed directly upstream of the word-only data memory `dmem`.
- Accepts byte, halfword and word load/store requests from the CPU's memory stage over a valid/ready handshake.
- Sub-word stores become a read-modify-write on the 32-bit memory port.
- Loads return sign- or zero-extended data. Misaligned and out-of-range accesses are flagged.

Parameters:
- NLOC, 64: number of 32-bit words in the attached memory. Word index = addr[31:2].
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be word aligned.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  4  mem_op_t operation code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load data (0 for stores)
- resp_fault  out  1  request was misaligned or out of range, valid with resp_valid
- mem_wr  out  1  write strobe to memory
- mem_addr  out  32  byte address to memory (word aligned)
- mem_writedata  out  32  write data to memory
- mem_readdata  in  32  combinational read data from memory

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_wr=0, mem_addr=0, mem_writedata=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch op, addr and wdata; req_ready is 0 in every other state.
    - Fault → RESP.
    - Load or sub-word store → READ.
    - SW → WRITE.
  - READ: mem_addr = latched addr & ~3. Capture mem_readdata into a holding register.
    - Load → RESP.
    - SB/SH → WRITE.
  - WRITE: mem_wr=1 for exactly this cycle.
    - mem_writedata = wdata (SW), or the held word with the target lane replaced (SB/SH) → RESP.
  - RESP: resp_valid=1 for exactly one cycle → IDLE.
    - resp_rdata and resp_fault hold their values until the next RESP.
- Latency from the accept cycle to resp_valid:
  - Loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Faults: 1 cycle.
  - The earliest next accept is the cycle after RESP.
- Lanes are little-endian:
  - Byte k occupies bits [8k+7:8k], with k = addr[1:0].
  - The halfword is at addr[1] ? [31:16] : [15:0].
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-fill.
  - LW passes through.
- Fault conditions (each suppresses the memory access; resp_rdata = 0):
  - Out of range: (addr − BASE_ADDR) >> 2 ≥ NLOC, or addr < BASE_ADDR.
  - Misaligned: only when MISALIGN_TRAP_EN is defined (see below).
- mem_addr holds its last value in IDLE. mem_wr is never asserted outside WRITE.
- Reset mid-operation:
  - The transaction is dropped and no response is issued.
  - mem_wr deasserts immediately (asynchronously).
  - A sub-word store aborted in READ leaves memory unmodified.
- req_valid deasserting after the accept has no effect. The request is already latched.
- Unknown req_op values are treated as a fault.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1 set resp_fault=1 and perform no memory access.
  - LW/SW with addr[1:0]≠0 do the same.
- Not defined:
  - Misaligned halfword accesses use addr[1] only (addr[0] is ignored).
  - Misaligned word accesses ignore addr[1:0].
  - Alignment never raises a fault; only the range check does.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic[3:0] mem_op_t: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10.
  - FSM state typedef acc_state_t.
  - Helper functions is_store(), size_of().
- One natural sub-module, dmem_lane_align (combinational):
  - Store lane merge: held word, wdata, addr[1:0], size → merged word.
  - Load extract and extend: word, addr[1:0], op → rdata.

Test Plan:
- SW 32'hDEADBEEF to 0x10, then LW 0x10 → write on the cycle after accept; LW resp_rdata=32'hDEADBEEF after 2 cycles, resp_fault=0.
- Memory word 0x10 = 32'h11223344:
  - SB wdata=8'hAA to 0x12 → one READ then one WRITE; word becomes 32'h11AA3344.
  - Following LB 0x12 → 32'hFFFFFFAA.
  - Following LBU 0x12 → 32'h000000AA.
- SH 16'h8001 to 0x16, then LH 0x16 → 32'hFFFF8001; LHU 0x16 → 32'h00008001; lower half of the word unchanged.
- LW at byte address NLOC*4 (0x100 at default) → resp_fault=1 one cycle after accept, mem_wr never asserted, resp_rdata=0.
- LW 0x13:
  - With MISALIGN_TRAP_EN → resp_fault=1, no access.
  - Without it → returns the word at 0x10.
- Assert rst_n=0 during WRITE of SW 0x20 = 32'h5 → mem_wr drops at once, no resp_valid, req_ready=1 after release; back-to-back requests afterwards complete normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store front-end.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package dmem_pkg;

  // CPU memory-stage operation codes; bit 3 marks a store, bits [1:0] the size.
  typedef enum logic [3:0] {
    LB  = 4'd0,
    LH  = 4'd1,
    LW  = 4'd2,
    LBU = 4'd4,
    LHU = 4'd5,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } acc_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } mem_size_t;

  function automatic logic is_store(input mem_op_t op);
    return op[3];
  endfunction

  function automatic mem_size_t size_of(input mem_op_t op);
    return mem_size_t'(op[1:0]);
  endfunction

  // Only the eight encodings above are legal; anything else faults.
  function automatic logic is_known(input logic [3:0] op);
    logic known;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: known = 1'b1;
      default:                                         known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: merges store data into a word and extracts/extends load data.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs in the same cycle.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] held_word,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  input  logic [1:0]  addr_lo,
  input  mem_op_t     op,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Store merge: replace only the addressed lane of the held word.
  always_comb begin
    merged_word = held_word;
    case (size_of(op))
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    merged_word[7:0]   = store_data[7:0];
          2'd1:    merged_word[15:8]  = store_data[7:0];
          2'd2:    merged_word[23:16] = store_data[7:0];
          default: merged_word[31:24] = store_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) merged_word[31:16] = store_data[15:0];
        else            merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

  // Load extract: pick the lane, then sign- or zero-extend by opcode.
  always_comb begin
    case (addr_lo)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (op)
      LB:      load_data = {{24{load_byte[7]}}, load_byte};
      LBU:     load_data = {24'd0, load_byte};
      LH:      load_data = {{16{load_half[15]}}, load_half};
      LHU:     load_data = {16'd0, load_half};
      LW:      load_data = load_word;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Byte/half/word load-store front-end for a word-only memory; sub-word stores are read-modify-write. Optional macro MISALIGN_TRAP_EN faults misaligned half/word accesses.
// Latency accept->resp: load 2, SW 2, SB/SH 3, fault 1 cycle.
// Backpressure: req_ready is high only in IDLE; one request in flight, next accept the cycle after resp_valid.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int          NLOC      = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  localparam logic [31:0] NLOC_W = 32'(NLOC);

  acc_state_t  state_q, state_d;
  mem_op_t     op_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic [31:0] hold_q;
  logic [31:0] mem_addr_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  mem_op_t     req_op_t;
  logic [29:0] off_word;
  logic        range_fault;
  logic        align_fault;
  logic        req_fault;
  logic        accept;
  logic [31:0] merged_word;
  logic [31:0] load_data;

  assign req_op_t = mem_op_t'(req_op);
  assign accept   = (state_q == IDLE) && req_valid;

  // Request decode: range check on the word index relative to BASE_ADDR (word aligned).
  always_comb begin
    off_word    = req_addr[31:2] - BASE_ADDR[31:2];
    range_fault = (req_addr < BASE_ADDR) || ({2'b00, off_word} >= NLOC_W);
`ifdef MISALIGN_TRAP_EN
    align_fault = ((size_of(req_op_t) == SZ_HALF) && req_addr[0]) ||
                  ((size_of(req_op_t) == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    align_fault = 1'b0;
`endif
    req_fault   = !is_known(req_op) || range_fault || align_fault;
  end

  dmem_lane_align u_lane_align (
    .held_word   (hold_q),
    .store_data  (wdata_q),
    .load_word   (mem_readdata),
    .addr_lo     (addr_lo_q),
    .op          (op_q),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  // State register; async reset drops any in-flight transaction and mem_wr with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/memory strobes, all decoded from the current state.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_wr        = 1'b0;
    mem_writedata = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault)                                         state_d = RESP;
          else if (is_store(req_op_t) && size_of(req_op_t) == SZ_WORD) state_d = WRITE;
          else                                                   state_d = READ;
        end
      end
      READ: begin
        state_d = is_store(op_q) ? WRITE : RESP;
      end
      WRITE: begin
        mem_wr        = 1'b1;
        mem_writedata = (size_of(op_q) == SZ_WORD) ? wdata_q : merged_word;
        state_d       = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  // Datapath: latch the request at accept, capture the memory word in READ,
  // and load the response registers on entry to RESP so they hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= LB;
      addr_lo_q  <= 2'b00;
      wdata_q    <= 32'd0;
      hold_q     <= 32'd0;
      mem_addr_q <= 32'd0;
      rdata_q    <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= req_op_t;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            if (req_fault) begin
              rdata_q <= 32'd0;
              fault_q <= 1'b1;
            end else begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
            end
          end
        end
        READ: begin
          hold_q <= mem_readdata;
          if (!is_store(op_q)) begin
            rdata_q <= load_data;
            fault_q <= 1'b0;
          end
        end
        WRITE: begin
          rdata_q <= 32'd0;
          fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule
